// File: rtl/div_issue_ctrl_pkg.sv
// Shared ALU divider-control types and constants.
package div_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Encoding matches funct3[1:0]: bit 0 = unsigned, bit 1 = remainder.
  typedef enum logic [1:0] {
    DivOpDiv  = 2'b00,
    DivOpDivu = 2'b01,
    DivOpRem  = 2'b10,
    DivOpRemu = 2'b11
  } div_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain,
    StDone
  } div_ctrl_state_t;

  localparam logic [XLEN-1:0] DIV_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] DIV_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic is_signed_op(div_op_t op);
    return !op[0];
  endfunction

endpackage

// File: rtl/div_reuse_cache.sv
// Single-entry cache of the last divider result; only built with DIV_RESULT_REUSE_EN.
`ifdef DIV_RESULT_REUSE_EN
module div_reuse_cache
  import div_issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fill,
  input  logic            clear,
  input  logic [XLEN-1:0] fill_rs1,
  input  logic [XLEN-1:0] fill_rs2,
  input  logic            fill_signed,
  input  logic [XLEN-1:0] fill_quotient,
  input  logic [XLEN-1:0] fill_remainder,
  input  logic [XLEN-1:0] lookup_rs1,
  input  logic [XLEN-1:0] lookup_rs2,
  input  logic            lookup_signed,
  output logic            hit,
  output logic [XLEN-1:0] hit_quotient,
  output logic [XLEN-1:0] hit_remainder
);

  logic            valid_q;
  logic [XLEN-1:0] rs1_q, rs2_q, quotient_q, remainder_q;
  logic            signed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      signed_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (fill) begin
      valid_q     <= 1'b1;
      rs1_q       <= fill_rs1;
      rs2_q       <= fill_rs2;
      signed_q    <= fill_signed;
      quotient_q  <= fill_quotient;
      remainder_q <= fill_remainder;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign hit = valid_q && (rs1_q == lookup_rs1) && (rs2_q == lookup_rs2) &&
               (signed_q == lookup_signed);
  assign hit_quotient  = quotient_q;
  assign hit_remainder = remainder_q;

endmodule
`endif

// File: rtl/div_issue_ctrl.sv
// RV32M divider issue/writeback controller with flush and watchdog.
// Define DIV_RESULT_REUSE_EN to reuse the last divider result for matching operands.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  div_op_t          in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic             div_signed,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic             div_valid,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int unsigned     WdogW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  div_ctrl_state_t  state_q, state_d;
  div_op_t          op_q, op_d;
  logic [XLEN-1:0]  dividend_q, dividend_d;
  logic [XLEN-1:0]  divisor_q, divisor_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             err_q, err_d;
  logic [WdogW-1:0] wdog_q, wdog_d;

  logic            in_div_zero, in_overflow, wdog_expired;
  logic            cache_hit;
  logic [XLEN-1:0] cache_quotient, cache_remainder;

  assign in_div_zero  = (in_rs2 == '0);
  assign in_overflow  = is_signed_op(in_op) && (in_rs1 == DIV_INT_MIN) &&
                        (in_rs2 == DIV_ALL_ONES);
  assign wdog_expired = (wdog_q == WdogLast);

`ifdef DIV_RESULT_REUSE_EN
  logic div_active, cache_fill, cache_clear;

  assign div_active  = (state_q == StWait) || (state_q == StDrain);
  // Drained results are still valid divider output, so they fill too.
  assign cache_fill  = div_active && div_valid;
  assign cache_clear = div_active && !div_valid && wdog_expired;

  div_reuse_cache u_reuse_cache (
    .clk            (clk),
    .rst            (rst),
    .fill           (cache_fill),
    .clear          (cache_clear),
    .fill_rs1       (dividend_q),
    .fill_rs2       (divisor_q),
    .fill_signed    (is_signed_op(op_q)),
    .fill_quotient  (div_quotient),
    .fill_remainder (div_remainder),
    .lookup_rs1     (in_rs1),
    .lookup_rs2     (in_rs2),
    .lookup_signed  (is_signed_op(in_op)),
    .hit            (cache_hit),
    .hit_quotient   (cache_quotient),
    .hit_remainder  (cache_remainder)
  );
`else
  assign cache_hit       = 1'b0;
  assign cache_quotient  = '0;
  assign cache_remainder = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= DivOpDiv;
      dividend_q <= '0;
      divisor_q  <= '0;
      tag_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    tag_d      = tag_q;
    result_d   = result_q;
    err_d      = err_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          op_d       = in_op;
          dividend_d = in_rs1;
          divisor_d  = in_rs2;
          tag_d      = in_tag;
          err_d      = 1'b0;
          state_d    = StDone;
          if (in_div_zero) begin
            result_d = in_op[1] ? in_rs1 : DIV_ALL_ONES;
          end else if (in_overflow) begin
            result_d = in_op[1] ? '0 : in_rs1;
          end else if (cache_hit) begin
            result_d = in_op[1] ? cache_remainder : cache_quotient;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        // Divider is already started, so a flush here must still drain it.
        wdog_d  = '0;
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        if (div_valid) begin
          result_d = op_q[1] ? div_remainder : div_quotient;
          err_d    = 1'b0;
          state_d  = flush ? StIdle : StDone;
        end else if (wdog_expired) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = flush ? StIdle : StDone;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
          if (flush) state_d = StDrain;
        end
      end
      StDrain: begin
        if (div_valid || wdog_expired) begin
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
        end
      end
      StDone: begin
        if (flush || out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready     = (state_q == StIdle);
  assign div_start    = (state_q == StIssue);
  assign div_signed   = (state_q inside {StIssue, StWait, StDrain}) && is_signed_op(op_q);
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign out_valid    = (state_q == StDone);
  assign out_result   = result_q;
  assign out_tag      = tag_q;
  assign out_err      = err_q;

endmodule
